// File: rtl/sprite_scan_ctrl_if.sv
// Sprite-position update channel between game logic (master) and the
// per-pixel scan controller (slave). Coin entries are 38 bits each, packed by index.
interface sprite_scan_ctrl_if #(
  parameter int N_COINS = 4
);
  logic                   upd_valid;
  logic                   upd_ready;
  logic [18:0]            upd_ghost_pos;
  logic [18:0]            upd_pacman_pos;
  logic [N_COINS*38-1:0]  upd_coin_pos;

  modport master (
    output upd_valid, upd_ghost_pos, upd_pacman_pos, upd_coin_pos,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_ghost_pos, upd_pacman_pos, upd_coin_pos,
    output upd_ready
  );
endinterface

// File: rtl/sprite_scan_ctrl.sv
// Per-pixel object scheduler: a two-stage pipeline that hit-tests each pixel against
// frame-stable sprite positions. Optional macro SPRITE_SCAN_COLLIDE_EN adds a per-frame collision output.
module sprite_scan_ctrl #(
  parameter  int SPR_SIZE  = 25,
  parameter  int COIN_SIZE = 15,
  parameter  int N_COINS   = 4,
  localparam int SEL_W     = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  input  logic                  is_wall,
  sprite_scan_ctrl_if.slave     upd,
  output logic [18:0]           curr_pos,
  output logic [2:0]            obj_type,
  output logic [SEL_W-1:0]      coin_sel,
  output logic                  pix_valid_out,
  output logic [18:0]           ghost_pos,
  output logic [18:0]           pacman_pos,
  output logic [N_COINS*38-1:0] coin_positions
`ifdef SPRITE_SCAN_COLLIDE_EN
  , output logic                collision
`endif
);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  typedef enum logic [2:0] {
    OBJ_WALL   = 3'd0,
    OBJ_GHOST  = 3'd2,
    OBJ_PACMAN = 3'd3,
    OBJ_COIN   = 3'd4,
    OBJ_BG     = 3'd7
  } obj_t;

  localparam logic [10:0] SPR_M1  = 11'(SPR_SIZE - 1);
  localparam logic [10:0] COIN_M1 = 11'(COIN_SIZE - 1);

  state_t state, state_nxt;
  logic   scan_en;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (frame_start) state_nxt = ACTIVE;
      ACTIVE:     state_nxt = ACTIVE;
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  always_comb begin
    scan_en = (state == ACTIVE);
  end

  // ---------------- update handshake / register banks ----------------
  logic                  pending_full;
  logic [18:0]           pend_ghost, pend_pacman;
  logic [N_COINS*38-1:0] pend_coins;
  logic                  xfer;

  assign upd.upd_ready = !pending_full;
  assign xfer          = upd.upd_valid && !pending_full;

  always_ff @(posedge clk) begin
    if (reset)            pending_full <= 1'b0;
    else if (xfer)        pending_full <= 1'b1;
    else if (frame_start) pending_full <= 1'b0;
  end

  // NOTE: pending data is deliberately not reset; it is only ever read when
  // pending_full is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_ghost  <= upd.upd_ghost_pos;
      pend_pacman <= upd.upd_pacman_pos;
      pend_coins  <= upd.upd_coin_pos;
    end
  end

  // Active bank changes only at frame start, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghost_pos      <= '0;
      pacman_pos     <= '0;
      coin_positions <= '0;
    end else if (frame_start && pending_full) begin
      ghost_pos      <= pend_ghost;
      pacman_pos     <= pend_pacman;
      coin_positions <= pend_coins;
    end
  end

  // ---------------- stage 1 ----------------
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic       s1_wall, s1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_wall  <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_x     <= x;
      s1_y     <= y;
      s1_wall  <= is_wall;
      s1_valid <= pix_valid;
    end
  end

  // ---------------- stage 2 hit tests ----------------
  // Bounds are widened by one bit so a sprite near the right/bottom edge never wraps.
  function automatic logic box_hit(input logic [9:0] px, input logic [8:0] py,
                                   input logic [18:0] o, input logic [10:0] m1);
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    x0 = {1'b0, o[18:9]};
    x1 = x0 + m1;
    y0 = {1'b0, o[8:0]};
    y1 = y0 + m1[9:0];
    return ({1'b0, px} >= x0) && ({1'b0, px} <= x1) &&
           ({1'b0, py} >= y0) && ({1'b0, py} <= y1);
  endfunction

  logic             pac_hit, ghost_hit, coin_hit;
  logic [SEL_W-1:0] coin_idx;
  obj_t             type_nxt;

  // NOTE: every combinationally driven signal gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    pac_hit   = box_hit(s1_x, s1_y, pacman_pos, SPR_M1);
    ghost_hit = box_hit(s1_x, s1_y, ghost_pos,  SPR_M1);
    coin_hit  = 1'b0;
    coin_idx  = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (!coin_hit && box_hit(s1_x, s1_y, coin_positions[i*38+19 +: 19], COIN_M1)) begin
        coin_hit = 1'b1;
        coin_idx = SEL_W'(i);
      end
    end

    type_nxt = OBJ_BG;
    if (!scan_en || !s1_valid) type_nxt = OBJ_BG;
    else if (pac_hit)          type_nxt = OBJ_PACMAN;
    else if (ghost_hit)        type_nxt = OBJ_GHOST;
    else if (coin_hit)         type_nxt = OBJ_COIN;
    else if (s1_wall)          type_nxt = OBJ_WALL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_pos      <= '0;
      obj_type      <= OBJ_BG;
      coin_sel      <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      curr_pos      <= {s1_x, s1_y};
      obj_type      <= type_nxt;
      coin_sel      <= coin_idx;
      pix_valid_out <= scan_en && s1_valid;
    end
  end

`ifdef SPRITE_SCAN_COLLIDE_EN
  // Sticky overlap flag for the current frame; published at the next frame start.
  logic collide_sticky;

  always_ff @(posedge clk) begin
    if (reset) begin
      collide_sticky <= 1'b0;
      collision      <= 1'b0;
    end else if (frame_start) begin
      collision      <= collide_sticky;
      collide_sticky <= 1'b0;
    end else if (scan_en && s1_valid && pac_hit && ghost_hit) begin
      collide_sticky <= 1'b1;
    end
  end
`endif

endmodule
